axis_channel_selector: RTL and testbench
========================================

AXIS_CHANNEL_SELECTOR -- requirements
Module: axis_channel_selector

Interface
REQ-001 SHALL have parameter DOUT_WIDTH, default 32, meaning width of one channel word in bits.
REQ-002 SHALL have parameter CH_COUNT, default 6, meaning number of packed channels (1..16).
REQ-003 SHALL have parameter SEL_WIDTH, default 3, meaning width of cfg_sel; 2**SEL_WIDTH >= CH_COUNT.
REQ-004 SHALL have port aclk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port areset  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port cfg_sel  input  SEL_WIDTH  channel index used in single mode.
REQ-007 SHALL have port cfg_mode  input  1  0 = single channel, 1 = round-robin serialise all channels.
REQ-008 SHALL have port s_axis_tdata  input  CH_COUNT*DOUT_WIDTH  packed channels; channel k at bits [(k+1)*DOUT_WIDTH-1 : k*DOUT_WIDTH].
REQ-009 SHALL have port s_axis_tvalid  input  1  input vector valid.
REQ-010 SHALL have port s_axis_tready  output  1  input vector accepted when tvalid and tready both high.
REQ-011 SHALL have port m_axis_tdata  output  DOUT_WIDTH  selected channel word, registered.
REQ-012 SHALL have port m_axis_tvalid  output  1  output word valid, registered.
REQ-013 SHALL have port m_axis_tready  input  1  downstream ready.
REQ-014 SHALL have port m_axis_tlast  output  1  marks final word of a group, registered.

Function
REQ-015 SHALL sample cfg_sel and cfg_mode only on the cycle an input vector is accepted, and hold them (sel_q, mode_q) for the whole group; cfg changes mid-group SHALL have no effect on that group.
REQ-016 SHALL drive s_axis_tready = !areset && (!m_axis_tvalid || (m_axis_tready && m_axis_tlast)), combinationally.
REQ-017 SHALL, on input acceptance with cfg_mode=0, load m_axis_tdata with channel cfg_sel, set m_axis_tlast=1, m_axis_tvalid=1 on the next edge (latency 1 cycle).
REQ-018 SHALL, in mode 0 with cfg_sel >= CH_COUNT, output channel 0.
REQ-019 SHALL, on input acceptance with cfg_mode=1, store the full input vector in an internal buffer, output channel 0 next cycle, set index counter to 1, set m_axis_tlast = (CH_COUNT==1).
REQ-020 SHALL, in mode 1, on each output handshake with m_axis_tlast=0, load buffered channel [index], increment index, set m_axis_tlast=1 when that loaded channel is CH_COUNT-1.
REQ-021 SHALL emit exactly CH_COUNT words per mode-1 group, channel order 0,1,...,CH_COUNT-1, with no idle cycle between words while m_axis_tready stays high.
REQ-022 SHALL, on output handshake with m_axis_tlast=1 and simultaneous input acceptance, load the new group's first word on the same edge (back-to-back, 1 word per cycle sustained).
REQ-023 SHALL, on output handshake with m_axis_tlast=1 and no input acceptance, clear m_axis_tvalid on the next edge.
REQ-024 SHALL hold m_axis_tdata, m_axis_tlast and m_axis_tvalid stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-025 SHALL never drop or duplicate a word; s_axis_tdata is ignored when no handshake occurs.

Reset
REQ-026 SHALL, while areset=1 at a rising edge, set m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, index=0, sel_q=0, mode_q=0, buffer=0.
REQ-027 SHALL hold s_axis_tready=0 while areset=1.
REQ-028 SHALL abandon any partially emitted mode-1 group on reset; after release, the first output is from the next accepted input vector.

Verification
REQ-029 Mode 0, CH_COUNT=6, cfg_sel=4, input channels k = 0x100+k, m_axis_tready=1, tvalid held 4 cycles -> 4 words 0x104, each tlast=1, first word one cycle after first accept, tready constantly 1.
REQ-030 Mode 0, cfg_sel=7 -> output 0x100 (channel 0) with tlast=1.
REQ-031 Mode 1, one vector 0x100..0x105 -> words 0x100..0x105 on 6 consecutive cycles, tlast only on 0x105, s_axis_tready=0 for cycles 2..6 after accept, 1 again in the cycle 0x105 is accepted.
REQ-032 Mode 1, m_axis_tready toggled 1,0,0,1,... -> data/tlast stable during stalls, still exactly 0x100..0x105 in order; cfg_mode changed to 0 and cfg_sel changed mid-group -> current group unaffected, next group single-channel.
REQ-033 Mode 1, two vectors offered back-to-back -> 12 words with no bubble, second group's 0x2xx words start the cycle after first group's tlast handshake.
REQ-034 areset=1 asserted after third word of a mode-1 group -> next edge tvalid=0, tlast=0, tdata=0, tready=0 during reset; after release next vector produces its channel 0 first.

Source files
------------

// File: rtl/axis_channel_selector.sv
// AXI-Stream channel selector: forwards one channel of a packed input vector,
// or serialises every channel of the vector in order as a tlast-terminated group.
module axis_channel_selector #(
    parameter int DOUT_WIDTH = 32,
    parameter int CH_COUNT   = 6,
    parameter int SEL_WIDTH  = 3
) (
    input  logic                           aclk,
    input  logic                           areset,
    input  logic [SEL_WIDTH-1:0]           cfg_sel,
    input  logic                           cfg_mode,
    input  logic [CH_COUNT*DOUT_WIDTH-1:0] s_axis_tdata,
    input  logic                           s_axis_tvalid,
    output logic                           s_axis_tready,
    output logic [DOUT_WIDTH-1:0]          m_axis_tdata,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic                           m_axis_tlast
);

    localparam int                IDX_W    = $clog2(CH_COUNT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CH_COUNT - 1);

    logic [DOUT_WIDTH-1:0]          m_tdata_q, m_tdata_d;
    logic                           m_tvalid_q, m_tvalid_d;
    logic                           m_tlast_q, m_tlast_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [SEL_WIDTH-1:0]           sel_q, sel_d;
    logic                           mode_q, mode_d;
    logic [CH_COUNT*DOUT_WIDTH-1:0] buf_q, buf_d;

    logic                  in_hs;
    logic                  out_hs;
    logic [DOUT_WIDTH-1:0] sel_word;
    logic [DOUT_WIDTH-1:0] buf_word;

    // A new vector is taken only when the output register is free or its last word leaves now.
    assign s_axis_tready = !areset && (!m_tvalid_q || (m_axis_tready && m_tlast_q));
    assign in_hs         = s_axis_tvalid && s_axis_tready;
    assign out_hs        = m_tvalid_q && m_axis_tready;

    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tvalid = m_tvalid_q;
    assign m_axis_tlast  = m_tlast_q;

    // Out-of-range selects fall through to the channel-0 default.
    always_comb begin
        sel_word = s_axis_tdata[DOUT_WIDTH-1:0];
        for (int k = 0; k < CH_COUNT; k++) begin
            if (cfg_sel == SEL_WIDTH'(k)) begin
                sel_word = s_axis_tdata[k*DOUT_WIDTH +: DOUT_WIDTH];
            end
        end
    end

    always_comb begin
        buf_word = buf_q[DOUT_WIDTH-1:0];
        for (int k = 0; k < CH_COUNT; k++) begin
            if (idx_q == IDX_W'(k)) begin
                buf_word = buf_q[k*DOUT_WIDTH +: DOUT_WIDTH];
            end
        end
    end

    always_comb begin
        m_tdata_d  = m_tdata_q;
        m_tvalid_d = m_tvalid_q;
        m_tlast_d  = m_tlast_q;
        idx_d      = idx_q;
        sel_d      = sel_q;
        mode_d     = mode_q;
        buf_d      = buf_q;

        if (in_hs) begin
            sel_d      = cfg_sel;
            mode_d     = cfg_mode;
            m_tvalid_d = 1'b1;
            if (!cfg_mode) begin
                m_tdata_d = sel_word;
                m_tlast_d = 1'b1;
            end else begin
                buf_d     = s_axis_tdata;
                m_tdata_d = s_axis_tdata[DOUT_WIDTH-1:0];
                idx_d     = IDX_W'(1);
                m_tlast_d = (CH_COUNT == 1);
            end
        end else if (out_hs) begin
            if (m_tlast_q) begin
                m_tvalid_d = 1'b0;
            end else if (mode_q) begin
                m_tdata_d = buf_word;
                m_tlast_d = (idx_q == LAST_IDX);
                idx_d     = idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            m_tdata_q  <= '0;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            idx_q      <= '0;
            sel_q      <= '0;
            mode_q     <= 1'b0;
            buf_q      <= '0;
        end else begin
            m_tdata_q  <= m_tdata_d;
            m_tvalid_q <= m_tvalid_d;
            m_tlast_q  <= m_tlast_d;
            idx_q      <= idx_d;
            sel_q      <= sel_d;
            mode_q     <= mode_d;
            buf_q      <= buf_d;
        end
    end

endmodule

// File: tb/tb_axis_channel_selector.sv
// Directed bench for axis_channel_selector: scoreboard of expected {tlast,tdata}
// words filled when a vector is accepted, compared against words seen leaving the DUT.
module tb_axis_channel_selector;

    localparam int DW = 32;
    localparam int CH = 6;
    localparam int SW = 3;

    logic              aclk = 1'b0;
    logic              areset = 1'b1;
    logic [SW-1:0]     cfg_sel = '0;
    logic              cfg_mode = 1'b0;
    logic [CH*DW-1:0]  s_axis_tdata = '0;
    logic              s_axis_tvalid = 1'b0;
    logic              s_axis_tready;
    logic [DW-1:0]     m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready = 1'b1;
    logic              m_axis_tlast;

    axis_channel_selector #(.DOUT_WIDTH(DW), .CH_COUNT(CH), .SEL_WIDTH(SW)) dut (
        .aclk          (aclk),
        .areset        (areset),
        .cfg_sel       (cfg_sel),
        .cfg_mode      (cfg_mode),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    // Output monitor: a word seen with valid&ready at a falling edge is taken at the next rising edge.
    logic [DW:0] obs_q [0:511];
    int          obs_cyc [0:511];
    int          obs_wr = 0;
    int          stall_cnt = 0;
    int          stall_bad = 0;
    logic        prev_stall = 1'b0;
    logic [DW:0] prev_out = '0;

    always @(negedge aclk) begin
        if (prev_stall && !(m_axis_tvalid === 1'b1 && {m_axis_tlast, m_axis_tdata} === prev_out))
            stall_bad <= stall_bad + 1;
        prev_stall <= !areset && m_axis_tvalid && !m_axis_tready;
        if (!areset && m_axis_tvalid && !m_axis_tready)
            stall_cnt <= stall_cnt + 1;
        prev_out <= {m_axis_tlast, m_axis_tdata};
        if (!areset && m_axis_tvalid && m_axis_tready && obs_wr < 512) begin
            obs_q[obs_wr]   <= {m_axis_tlast, m_axis_tdata};
            obs_cyc[obs_wr] <= cyc + 1;
            obs_wr          <= obs_wr + 1;
        end
    end

    int          checks = 0;
    int          failures = 0;
    int          rd = 0;
    logic [DW:0] exp_q [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic send_vec(input logic [DW-1:0] base, input logic mode, input logic [SW-1:0] sel,
                            output int acc, output int waits);
        int s;
        for (int k = 0; k < CH; k++) s_axis_tdata[k*DW +: DW] = base + DW'(k);
        cfg_mode      = mode;
        cfg_sel       = sel;
        s_axis_tvalid = 1'b1;
        acc   = -1;
        waits = 0;
        for (int i = 0; i < 100 && acc < 0; i++) begin
            @(negedge aclk);
            if (s_axis_tready) acc = cyc + 1;
            else waits++;
            @(posedge aclk);
            #1;
        end
        s_axis_tvalid = 1'b0;
        chk("accept", 64'(acc >= 0), 64'(1));
        if (!mode) begin
            s = (int'(sel) < CH) ? int'(sel) : 0;
            exp_q.push_back({1'b1, base + DW'(s)});
        end else begin
            for (int k = 0; k < CH; k++) exp_q.push_back({(k == CH - 1), base + DW'(k)});
        end
    endtask

    task automatic drain(input bit toggle);
        int n;
        for (int i = 0; i < 300 && obs_wr < rd + exp_q.size(); i++) begin
            if (toggle) m_axis_tready = ((i % 4) == 0) || ((i % 4) == 3);
            step();
        end
        m_axis_tready = 1'b1;
        n = exp_q.size();
        chk("word_count", 64'(obs_wr - rd), 64'(n));
        while (exp_q.size() > 0 && rd < obs_wr) begin
            chk("word", 64'(obs_q[rd]), 64'(exp_q.pop_front()));
            rd++;
        end
        exp_q.delete();
        repeat (3) step();
        chk("no_extra", 64'(obs_wr), 64'(rd));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0, acc1, w, r0;

        // Reset state
        repeat (3) step();
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
        chk("rst_tlast", 64'(m_axis_tlast), 64'(0));
        chk("rst_tdata", 64'(m_axis_tdata), 64'(0));
        chk("rst_s_tready", 64'(s_axis_tready), 64'(0));
        areset = 1'b0;
        step();
        chk("idle_s_tready", 64'(s_axis_tready), 64'(1));

        // Mode 0, sel 4, four vectors back-to-back
        r0 = rd;
        send_vec(32'h100, 1'b0, 3'd4, acc0, w);
        chk("m0_wait0", 64'(w), 64'(0));
        for (int j = 1; j < 4; j++) begin
            send_vec(32'h100, 1'b0, 3'd4, acc1, w);
            chk("m0_wait", 64'(w), 64'(0));
        end
        drain(1'b0);
        chk("m0_latency", 64'(obs_cyc[r0]), 64'(acc0 + 1));
        chk("m0_last_cyc", 64'(obs_cyc[r0 + 3]), 64'(acc0 + 4));

        // Mode 0, out-of-range select
        send_vec(32'h100, 1'b0, 3'd7, acc0, w);
        drain(1'b0);

        // Mode 1, single vector; tready low until the last word is presented
        r0 = rd;
        send_vec(32'h100, 1'b1, 3'd0, acc0, w);
        for (int i = 1; i <= 6; i++) begin
            @(negedge aclk);
            chk("m1_s_tready", 64'(s_axis_tready), 64'(i == 6));
        end
        @(posedge aclk);
        #1;
        drain(1'b0);
        chk("m1_first_cyc", 64'(obs_cyc[r0]), 64'(acc0 + 1));
        chk("m1_last_cyc", 64'(obs_cyc[r0 + 5]), 64'(acc0 + 6));

        // Mode 1 with downstream stalls and cfg changed mid-group
        send_vec(32'h100, 1'b1, 3'd0, acc0, w);
        cfg_mode = 1'b0;
        cfg_sel  = 3'd2;
        drain(1'b1);
        chk("stall_hold", 64'(stall_bad), 64'(0));
        chk("stall_seen", 64'(stall_cnt > 0), 64'(1));
        send_vec(32'h200, 1'b0, 3'd2, acc0, w);
        drain(1'b0);

        // Mode 1, two vectors back-to-back
        r0 = rd;
        send_vec(32'h100, 1'b1, 3'd0, acc0, w);
        send_vec(32'h200, 1'b1, 3'd0, acc1, w);
        chk("b2b_accept2", 64'(acc1), 64'(acc0 + 6));
        drain(1'b0);
        chk("b2b_second_first", 64'(obs_cyc[r0 + 6]), 64'(acc0 + 7));
        chk("b2b_last_cyc", 64'(obs_cyc[r0 + 11]), 64'(acc0 + 12));

        // Reset after the third word of a mode-1 group
        send_vec(32'h100, 1'b1, 3'd0, acc0, w);
        for (int i = 0; i < 50 && (obs_wr - rd) < 3; i++) step();
        areset = 1'b1;
        for (int k = 0; k < CH; k++) s_axis_tdata[k*DW +: DW] = 32'h900 + DW'(k);
        cfg_mode      = 1'b1;
        s_axis_tvalid = 1'b1;
        step();
        chk("arst_tvalid", 64'(m_axis_tvalid), 64'(0));
        chk("arst_tlast", 64'(m_axis_tlast), 64'(0));
        chk("arst_tdata", 64'(m_axis_tdata), 64'(0));
        chk("arst_s_tready", 64'(s_axis_tready), 64'(0));
        step();
        chk("arst_s_tready2", 64'(s_axis_tready), 64'(0));
        chk("arst_words_before", 64'(obs_wr - rd), 64'(3));
        for (int i = 0; i < 3 && rd < obs_wr; i++) begin
            chk("arst_word", 64'(obs_q[rd]), 64'(exp_q.pop_front()));
            rd++;
        end
        exp_q.delete();
        s_axis_tvalid = 1'b0;
        areset = 1'b0;
        step();
        send_vec(32'h300, 1'b1, 3'd0, acc0, w);
        drain(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
